// File: rtl/skewed_input_buffer_pkg.sv
// Shared configuration for the skewed input buffer.
// Holds array geometry and the streaming FSM state type.
package Config;

  localparam int sys_rows           = 4;
  localparam int A_BITWIDTH         = 8;
  localparam int input_buffer_depth = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/skewed_input_buffer_lane_fifo.sv
// Single-clock per-lane FIFO; reads of an empty lane return zero.
// INBUF_REPLAY_EN adds a read-pointer mark/restore for tile replay.
module lane_fifo
  import Config::*;
#(
  parameter int DWIDTH = A_BITWIDTH,
  parameter int DEPTH  = input_buffer_depth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
`ifdef INBUF_REPLAY_EN
  input  logic              mark,
  input  logic              restore,
`endif
  output logic [DWIDTH-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;
  logic              do_rd, do_wr, pop_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_rd = rd_en & ~empty;

`ifdef INBUF_REPLAY_EN
  logic [AW:0] mark_q, mark_d;

  // A restoring read frees no slot, so it cannot absorb a full write.
  assign pop_ok = do_rd & ~restore;
`else
  assign pop_ok = do_rd;
`endif

  assign do_wr     = wr_en & (~full | pop_ok);
  assign overflow  = wr_en & ~do_wr;
  assign underflow = rd_en & empty;
  assign rd_data   = rd_data_q;

  always_comb begin
    wptr_d    = wptr_q + (AW+1)'(do_wr);
    rptr_d    = rptr_q + (AW+1)'(do_rd);
    rd_data_d = do_rd ? mem_q[rptr_q[AW-1:0]] : '0;
`ifdef INBUF_REPLAY_EN
    mark_d = mark ? rptr_q : mark_q;
    if (restore) rptr_d = mark_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_data_q <= '0;
`ifdef INBUF_REPLAY_EN
      mark_q    <= '0;
`endif
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_data_q <= rd_data_d;
`ifdef INBUF_REPLAY_EN
      mark_q    <= mark_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/skewed_input_buffer.sv
// Per-lane input buffers streamed into a systolic array with row skew.
// Optional INBUF_REPLAY_EN adds a replay port to re-stream a tile.
module skewed_input_buffer
  import Config::*;
#(
  parameter int ROWS   = sys_rows,
  parameter int DWIDTH = A_BITWIDTH,
  parameter int DEPTH  = input_buffer_depth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS-1:0]               wr_en,
  input  logic [ROWS-1:0][DWIDTH-1:0]   wr_data,
  input  logic                          start,
  input  logic [$clog2(DEPTH+1)-1:0]    len,
`ifdef INBUF_REPLAY_EN
  input  logic                          replay,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [ROWS-1:0]               o_valid,
  output logic [ROWS-1:0][DWIDTH-1:0]   o_data,
  output logic [ROWS-1:0]               full,
  output logic [ROWS-1:0]               empty,
  output logic                          err
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(DEPTH+ROWS+1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic [ROWS-2:0] skew_q, skew_d;
  logic [ROWS-1:0] o_valid_q, o_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            accept, last0;
  logic [ROWS-1:0] rd_en, ovf, udf;

  assign accept = start & ~busy_q & (len != '0);
  assign last0  = (state_q == STREAM) &&
                  (cnt_q == CW'(len_q) - CW'(1));

  // Lane 0 reads during STREAM; each further lane trails by a cycle.
  assign rd_en  = {skew_q, state_q == STREAM};
  assign skew_d = rd_en[ROWS-2:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STREAM;
          cnt_d   = '0;
          len_d   = len;
        end
      end
      STREAM: begin
        cnt_d = cnt_q + CW'(1);
        if (last0) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ROWS-2)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_d    = (state_q == DRAIN) && (cnt_q == CW'(ROWS-2));
    busy_d    = accept | (busy_q & ~done_q);
    err_d     = err_q | (|ovf) | (|udf);
    o_valid_d = rd_en;
  end

`ifdef INBUF_REPLAY_EN
  logic            replay_q, replay_d;
  logic [ROWS-2:0] last_q, last_d;
  logic [ROWS-1:0] lastv, restore;

  assign lastv    = {last_q, last0};
  assign last_d   = lastv[ROWS-2:0];
  assign restore  = replay_q ? lastv : '0;
  assign replay_d = accept ? replay : replay_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q <= 1'b0;
      last_q   <= '0;
    end else begin
      replay_q <= replay_d;
      last_q   <= last_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      skew_q    <= '0;
      o_valid_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      skew_q    <= skew_d;
      o_valid_q <= o_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    lane_fifo #(
      .DWIDTH(DWIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_data  (wr_data[i]),
      .rd_en    (rd_en[i]),
`ifdef INBUF_REPLAY_EN
      .mark     (accept),
      .restore  (restore[i]),
`endif
      .rd_data  (o_data[i]),
      .full     (full[i]),
      .empty    (empty[i]),
      .overflow (ovf[i]),
      .underflow(udf[i])
    );
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign o_valid = o_valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_skewed_input_buffer.sv
// Directed bench for skewed_input_buffer (ROWS=4, DEPTH=8, DWIDTH=8).
// Build with +define+INBUF_REPLAY_EN to also exercise tile replay.
module tb_skewed_input_buffer;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      wr_en = '0;
  logic [3:0][7:0] wr_data = '0;
  logic            start = 1'b0;
  logic [3:0]      len = '0;
  logic            replay = 1'b0;
  logic            busy, done, err;
  logic [3:0]      o_valid, full, empty;
  logic [3:0][7:0] o_data;

  int passed = 0;
  int total  = 0;

  logic [3:0]      ov [16];
  logic [3:0][7:0] od [16];
  logic            dn [16];
  logic            bz [16];

  always #5 clk = ~clk;

  skewed_input_buffer #(
    .ROWS  (4),
    .DWIDTH(8),
    .DEPTH (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .start  (start),
    .len    (len),
`ifdef INBUF_REPLAY_EN
    .replay (replay),
`endif
    .busy   (busy),
    .done   (done),
    .o_valid(o_valid),
    .o_data (o_data),
    .full   (full),
    .empty  (empty),
    .err    (err)
  );

  function automatic logic [7:0] val(input int i, input int k);
    return 8'(16 * (i + 1) + k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic write_vec(input logic [3:0] mask, input int k);
    wr_en = mask;
    for (int i = 0; i < 4; i++) wr_data[i] = val(i, k);
    tick();
    wr_en = '0;
  endtask

  // Issue start and record outputs for cycles 1..ncyc after it.
  task automatic run_tile(input int n, input int ncyc);
    start = 1'b1;
    len   = 4'(n);
    tick();
    start = 1'b0;
    len   = '0;
    for (int c = 1; c <= ncyc; c++) begin
      ov[c] = o_valid;
      od[c] = o_data;
      dn[c] = done;
      bz[c] = busy;
      tick();
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({busy, done, err} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {busy, done, err});
    else passed++;
    total++;
    if (o_valid !== 4'h0 || o_data !== 32'h0)
      $display("FAIL reset_out: got %h/%h expected 0/0", o_valid, o_data);
    else passed++;
    total++;
    if (empty !== 4'hF || full !== 4'h0)
      $display("FAIL reset_status: got e=%b f=%b expected e=1111 f=0000",
               empty, full);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [3:0] ev;
    apply_reset();
    for (int k = 0; k < 3; k++) write_vec(4'hF, k);
    run_tile(3, 9);
    for (int c = 1; c <= 9; c++) begin
      ev = '0;
      for (int i = 0; i < 4; i++) ev[i] = (c >= 2 + i) && (c <= 4 + i);
      total++;
      if (ov[c] !== ev)
        $display("FAIL stream_valid c%0d: got %b expected %b", c, ov[c], ev);
      else passed++;
      total++;
      if (dn[c] !== (c == 7))
        $display("FAIL stream_done c%0d: got %b expected %b", c, dn[c], c == 7);
      else passed++;
      total++;
      if (bz[c] !== (c <= 7))
        $display("FAIL stream_busy c%0d: got %b expected %b", c, bz[c], c <= 7);
      else passed++;
      for (int i = 0; i < 4; i++) begin
        if (ev[i]) begin
          total++;
          if (od[c][i] !== val(i, c - 2 - i))
            $display("FAIL stream_data c%0d l%0d: got %h expected %h",
                     c, i, od[c][i], val(i, c - 2 - i));
          else passed++;
        end
      end
    end
    total++;
    if (err !== 1'b0 || empty !== 4'hF)
      $display("FAIL stream_end: got err=%b e=%b expected 0/1111", err, empty);
    else passed++;
  endtask

  task automatic test_underflow();
    logic [7:0] ed;
    apply_reset();
    write_vec(4'hF, 0);
    for (int k = 1; k < 3; k++) write_vec(4'hB, k);
    total++;
    if (err !== 1'b0)
      $display("FAIL underflow_pre_err: got %b expected 0", err);
    else passed++;
    run_tile(3, 8);
    for (int c = 4; c <= 6; c++) begin
      ed = (c == 4) ? val(2, 0) : 8'h00;
      total++;
      if (ov[c][2] !== 1'b1 || od[c][2] !== ed)
        $display("FAIL underflow_l2 c%0d: got v=%b d=%h expected v=1 d=%h",
                 c, ov[c][2], od[c][2], ed);
      else passed++;
    end
    total++;
    if (od[6][3] !== val(3, 1))
      $display("FAIL underflow_l3: got %h expected %h", od[6][3], val(3, 1));
    else passed++;
    total++;
    if (err !== 1'b1)
      $display("FAIL underflow_err: got %b expected 1", err);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] ed;
    apply_reset();
    write_vec(4'hF, 0);
    for (int k = 1; k < 8; k++) write_vec(4'h1, k);
    total++;
    if (full !== 4'h1 || err !== 1'b0)
      $display("FAIL ovf_full: got f=%b err=%b expected 0001/0", full, err);
    else passed++;
    start = 1'b1;
    len   = 4'd1;
    tick();
    start = 1'b0;
    wr_en = 4'h1;
    wr_data[0] = 8'hAA;
    tick();
    wr_en = '0;
    total++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== val(0, 0))
      $display("FAIL ovf_rd: got v=%b d=%h expected 1/%h",
               o_valid[0], o_data[0], val(0, 0));
    else passed++;
    for (int c = 0; c < 6; c++) tick();
    total++;
    if (full !== 4'h1 || err !== 1'b0)
      $display("FAIL ovf_concurrent: got f=%b err=%b expected 0001/0",
               full, err);
    else passed++;
    wr_en = 4'h1;
    wr_data[0] = 8'hBB;
    tick();
    wr_en = '0;
    total++;
    if (err !== 1'b1 || full !== 4'h1)
      $display("FAIL ovf_drop: got err=%b f=%b expected 1/0001", err, full);
    else passed++;
    run_tile(8, 13);
    for (int c = 2; c <= 9; c++) begin
      ed = (c == 9) ? 8'hAA : val(0, c - 1);
      total++;
      if (ov[c][0] !== 1'b1 || od[c][0] !== ed)
        $display("FAIL ovf_data c%0d: got v=%b d=%h expected v=1 d=%h",
                 c, ov[c][0], od[c][0], ed);
      else passed++;
    end
    total++;
    if (empty[0] !== 1'b1)
      $display("FAIL ovf_empty: got %b expected 1", empty[0]);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int k = 0; k < 3; k++) write_vec(4'hF, k);
    start = 1'b1;
    len   = 4'd3;
    tick();
    start = 1'b0;
    len   = '0;
    tick();
    total++;
    if (busy !== 1'b1)
      $display("FAIL mid_busy_before: got %b expected 1", busy);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, err} !== 3'b000 || o_valid !== 4'h0 || o_data !== 32'h0)
      $display("FAIL mid_outputs: got %b/%b/%h expected 000/0000/0",
               {busy, done, err}, o_valid, o_data);
    else passed++;
    total++;
    if (empty !== 4'hF || full !== 4'h0)
      $display("FAIL mid_status: got e=%b f=%b expected 1111/0000",
               empty, full);
    else passed++;
    #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (done !== 1'b0 || o_valid !== 4'h0)
        $display("FAIL mid_no_done c%0d: got d=%b v=%b expected 0/0000",
                 c, done, o_valid);
      else passed++;
    end
  endtask

`ifdef INBUF_REPLAY_EN
  task automatic test_replay();
    logic [3:0] ev;
    apply_reset();
    for (int k = 0; k < 2; k++) write_vec(4'hF, k);
    for (int r = 0; r < 3; r++) begin
      replay = (r < 2);
      run_tile(2, 7);
      replay = 1'b0;
      for (int c = 1; c <= 7; c++) begin
        ev = '0;
        for (int i = 0; i < 4; i++) ev[i] = (c >= 2 + i) && (c <= 3 + i);
        total++;
        if (ov[c] !== ev)
          $display("FAIL replay_valid r%0d c%0d: got %b expected %b",
                   r, c, ov[c], ev);
        else passed++;
        for (int i = 0; i < 4; i++) begin
          if (ev[i]) begin
            total++;
            if (od[c][i] !== val(i, c - 2 - i))
              $display("FAIL replay_data r%0d c%0d l%0d: got %h expected %h",
                       r, c, i, od[c][i], val(i, c - 2 - i));
            else passed++;
          end
        end
      end
      total++;
      if (empty !== ((r < 2) ? 4'h0 : 4'hF) || err !== 1'b0)
        $display("FAIL replay_end r%0d: got e=%b err=%b", r, empty, err);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_underflow();
    test_overflow();
    test_reset_midstream();
`ifdef INBUF_REPLAY_EN
    test_replay();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
